// File: rtl/switch_stim_pkg.sv
// ---------------------------------------------------------------------------
// switch_stim_pkg
//   Shared definitions for the switch stimulus generator:
//     - state_t     : controller states (IDLE / BOUNCE / SETTLE)
//     - LFSR_WIDTH  : width of the pseudo-random source
//     - LFSR_TAPS   : Galois feedback mask for the 16-bit LFSR
//     - lfsr_next() : one Galois step (shift right, fold taps in when the
//                     bit shifted out is 1)
// ---------------------------------------------------------------------------
package switch_stim_pkg;

  localparam int unsigned LFSR_WIDTH = 16;
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // A nonzero state never maps to zero with these taps, so the sequence
  // cannot lock up as long as the seed is nonzero.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] value);
    logic [LFSR_WIDTH-1:0] shifted;
    shifted = {1'b0, value[LFSR_WIDTH-1:1]};
    if (value[0]) begin
      return shifted ^ LFSR_TAPS;
    end else begin
      return shifted;
    end
  endfunction

endpackage

// File: rtl/lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16
//   16-bit Galois LFSR that advances only when asked to. Used as the source
//   of glitch segment widths.
// Ports
//   i_Clk    in   1   clock
//   i_Rst    in   1   synchronous reset, active-high (loads c_SEED)
//   i_Step   in   1   advance one step on this edge
//   o_Value  out  16  current LFSR state (registered)
// ---------------------------------------------------------------------------
module lfsr16
  import switch_stim_pkg::*;
#(
  parameter logic [LFSR_WIDTH-1:0] c_SEED = 16'hACE1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Step,
  output logic [LFSR_WIDTH-1:0] o_Value
);

  // An all-zero seed would freeze the sequence forever.
  if (c_SEED == 16'h0000) begin : g_bad_seed
    $error("lfsr16: c_SEED must be nonzero");
  end

  logic [LFSR_WIDTH-1:0] value_r;

  // LFSR state register: reload seed on reset, step on request
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      value_r <= c_SEED;
    end else if (i_Step) begin
      value_r <= lfsr_next(value_r);
    end else begin
      value_r <= value_r;
    end
  end

  assign o_Value = value_r;

endmodule

// File: rtl/switch_bounce_gen.sv
// ---------------------------------------------------------------------------
// switch_bounce_gen
//   On command, moves o_Switch from its current level to a requested level
//   through a train of pseudo-random glitch segments, then holds the level
//   clean for a settle period before signalling completion.
//   Sequence for a level change: first edge in IDLE, 2*c_BOUNCE_COUNT more
//   edges in BOUNCE (each after a 1..c_BOUNCE_MAX_CYCLES segment), then a
//   c_SETTLE_CYCLES clean hold, then a one-cycle o_Done.
// Ports
//   i_Clk     in   1  system clock
//   i_Rst     in   1  synchronous reset, active-high
//   i_Start   in   1  command pulse, only honoured in IDLE
//   i_Level   in   1  requested switch level, sampled with i_Start
//   o_Switch  out  1  generated switch waveform (registered)
//   o_Busy    out  1  transition or settle hold in progress (registered)
//   o_Done    out  1  one-cycle completion pulse (registered)
// ---------------------------------------------------------------------------
module switch_bounce_gen
  import switch_stim_pkg::*;
#(
  parameter int unsigned           c_BOUNCE_MAX_CYCLES = 2048,
  parameter int unsigned           c_BOUNCE_COUNT      = 8,
  parameter int unsigned           c_SETTLE_CYCLES     = 100000,
  parameter logic [LFSR_WIDTH-1:0] c_LFSR_SEED         = 16'hACE1
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Start,
  input  logic i_Level,
  output logic o_Switch,
  output logic o_Busy,
  output logic o_Done
);

  localparam int unsigned SEG_W      = $clog2(c_BOUNCE_MAX_CYCLES + 1);
  localparam int unsigned SETTLE_W   = $clog2(c_SETTLE_CYCLES + 1);
  localparam int unsigned EDGE_TOTAL = 2 * c_BOUNCE_COUNT;
  // With no bounce pairs the edge counter is never used, but keep it 1 bit
  // wide so the declaration stays legal.
  localparam int unsigned EDGE_W     = (EDGE_TOTAL == 0) ? 1 : $clog2(EDGE_TOTAL + 1);

  localparam logic [31:0]         SEG_MASK    = 32'(c_BOUNCE_MAX_CYCLES - 1);
  localparam logic [SEG_W-1:0]    SEG_ONE     = SEG_W'(1);
  localparam logic [SEG_W-1:0]    SEG_ZERO    = SEG_W'(0);
  localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
  localparam logic [SETTLE_W-1:0] SETTLE_ZERO = SETTLE_W'(0);
  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(c_SETTLE_CYCLES);
  localparam logic [EDGE_W-1:0]   EDGE_ONE    = EDGE_W'(1);
  localparam logic [EDGE_W-1:0]   EDGE_ZERO   = EDGE_W'(0);
  localparam logic [EDGE_W-1:0]   EDGE_INIT   = EDGE_W'(EDGE_TOTAL);

  // Parameter sanity: the width mask relies on a power-of-two maximum.
  if ((c_BOUNCE_MAX_CYCLES < 2) ||
      ((c_BOUNCE_MAX_CYCLES & (c_BOUNCE_MAX_CYCLES - 1)) != 0)) begin : g_bad_max
    $error("switch_bounce_gen: c_BOUNCE_MAX_CYCLES must be a power of two >= 2");
  end
  if (c_BOUNCE_MAX_CYCLES > 65536) begin : g_max_too_big
    $error("switch_bounce_gen: c_BOUNCE_MAX_CYCLES exceeds the 16-bit LFSR range");
  end
  if (c_SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("switch_bounce_gen: c_SETTLE_CYCLES must be >= 1");
  end
  if (c_LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("switch_bounce_gen: c_LFSR_SEED must be nonzero");
  end

  // Registered state
  state_t                state_r;
  logic                  switch_r;
  logic                  busy_r;
  logic                  done_r;
  logic [SEG_W-1:0]      seg_r;
  logic [SETTLE_W-1:0]   settle_r;
  logic [EDGE_W-1:0]     edges_r;

  // Next-state values
  state_t                state_s;
  logic                  switch_s;
  logic                  busy_s;
  logic                  done_s;
  logic [SEG_W-1:0]      seg_s;
  logic [SETTLE_W-1:0]   settle_s;
  logic [EDGE_W-1:0]     edges_s;
  logic                  step_s;

  // Random segment width
  logic [LFSR_WIDTH-1:0] lfsr_s;
  logic [31:0]           masked_s;
  logic [SEG_W-1:0]      width_s;

  lfsr16 #(
    .c_SEED (c_LFSR_SEED)
  ) u_lfsr (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Step  (step_s),
    .o_Value (lfsr_s)
  );

  // Width is taken from the current LFSR value; the LFSR steps on the same
  // edge the width is loaded, so each segment consumes exactly one value.
  assign masked_s = 32'(lfsr_s) & SEG_MASK;
  assign width_s  = SEG_W'(masked_s) + SEG_ONE;

  // State and output register with synchronous reset
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_r  <= ST_IDLE;
      switch_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      seg_r    <= SEG_ZERO;
      settle_r <= SETTLE_ZERO;
      edges_r  <= EDGE_ZERO;
    end else begin
      state_r  <= state_s;
      switch_r <= switch_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      seg_r    <= seg_s;
      settle_r <= settle_s;
      edges_r  <= edges_s;
    end
  end

  // Next-state, counter and output decode
  always_comb begin
    state_s  = state_r;
    switch_s = switch_r;
    busy_s   = busy_r;
    done_s   = 1'b0;
    seg_s    = seg_r;
    settle_s = settle_r;
    edges_s  = edges_r;
    step_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        busy_s = 1'b0;
        if (i_Start) begin
          if (i_Level != switch_r) begin
            // First edge goes out immediately with the command.
            switch_s = ~switch_r;
            busy_s   = 1'b1;
            edges_s  = EDGE_INIT;
            seg_s    = width_s;
            step_s   = 1'b1;
            if (c_BOUNCE_COUNT == 0) begin
              state_s  = ST_SETTLE;
              settle_s = SETTLE_INIT;
            end else begin
              state_s  = ST_BOUNCE;
            end
          end else begin
            // Already at the requested level: acknowledge without moving.
            done_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_BOUNCE: begin
        // "<=" rather than "==" so a corrupted zero count still moves on
        // instead of wrapping through the whole counter range.
        if (seg_r <= SEG_ONE) begin
          switch_s = ~switch_r;
          edges_s  = edges_r - EDGE_ONE;
          seg_s    = width_s;
          step_s   = 1'b1;
          if (edges_r <= EDGE_ONE) begin
            state_s  = ST_SETTLE;
            settle_s = SETTLE_INIT;
          end else begin
            state_s  = ST_BOUNCE;
          end
        end else begin
          seg_s = seg_r - SEG_ONE;
        end
      end

      ST_SETTLE: begin
        if (settle_r <= SETTLE_ONE) begin
          busy_s   = 1'b0;
          done_s   = 1'b1;
          settle_s = SETTLE_ZERO;
          state_s  = ST_IDLE;
        end else begin
          settle_s = settle_r - SETTLE_ONE;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a quiet idle.
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  assign o_Switch = switch_r;
  assign o_Busy   = busy_r;
  assign o_Done   = done_r;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// ---------------------------------------------------------------------------
// tb_switch_bounce_gen
//   Bench for switch_bounce_gen (MAX=8, COUNT=3, SETTLE=20) plus a second
//   instance with COUNT=0. The main instance is compared every cycle with a
//   schedule-based model: on each accepted command the model precomputes
//   all toggle times from the LFSR sequence, then derives o_Switch, o_Busy
//   and o_Done from those times. Hand-computed toggle offsets pin the model.
// ---------------------------------------------------------------------------
module tb_switch_bounce_gen;

  localparam int MAXC   = 8;
  localparam int NB     = 3;
  localparam int SETTLE = 20;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst, start, level, sw, busy, done;
  logic start0, level0, sw0, busy0, done0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  switch_bounce_gen #(
    .c_BOUNCE_MAX_CYCLES (MAXC),
    .c_BOUNCE_COUNT      (NB),
    .c_SETTLE_CYCLES     (SETTLE),
    .c_LFSR_SEED         (SEED)
  ) dut (
    .i_Clk (clk), .i_Rst (rst), .i_Start (start), .i_Level (level),
    .o_Switch (sw), .o_Busy (busy), .o_Done (done)
  );

  switch_bounce_gen #(
    .c_BOUNCE_MAX_CYCLES (MAXC),
    .c_BOUNCE_COUNT      (0),
    .c_SETTLE_CYCLES     (SETTLE),
    .c_LFSR_SEED         (SEED)
  ) dut0 (
    .i_Clk (clk), .i_Rst (rst), .i_Start (start0), .i_Level (level0),
    .o_Switch (sw0), .o_Busy (busy0), .o_Done (done0)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model (main instance) ----------------
  int          cyc = 0;
  bit          mvalid = 1'b0;
  logic        m_sw = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  logic [15:0] m_lfsr = SEED;
  int          sched[$];
  int          start_at = -1, done_at = -1;

  function automatic int seg_width(input logic [15:0] l);
    return 1 + int'(l & 16'(MAXC - 1));
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  task automatic model_step();
    logic [15:0] l;
    int t;
    cyc++;
    if (rst) begin
      m_sw = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_lfsr = SEED;
      sched.delete(); start_at = -1; done_at = -1; mvalid = 1'b1;
    end else begin
      if (!m_busy && start) begin
        if (level != m_sw) begin
          l = m_lfsr; t = cyc;
          for (int k = 0; k < 2*NB+1; k++) begin
            sched.push_back(t);
            t = t + seg_width(l);
            l = lfsr_step(l);
          end
          m_lfsr = l;
          start_at = cyc;
          done_at = sched[$] + SETTLE;
        end else begin
          start_at = cyc;
          done_at = cyc;
        end
      end
      if (sched.size() > 0 && sched[0] == cyc) begin
        m_sw = ~m_sw;
        void'(sched.pop_front());
      end
      m_busy = (cyc >= start_at) && (cyc < done_at);
      m_done = (cyc == done_at);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare and event logging ----------------
  int   tog_q[$], done_log[$], tog0_q[$], done0_log[$];
  logic prev_sw = 1'b0, prev_sw0 = 1'b0;

  initial forever begin
    @(negedge clk);
    if (mvalid) begin
      chk("o_Switch_vs_model", int'(sw), int'(m_sw));
      chk("o_Busy_vs_model", int'(busy), int'(m_busy));
      chk("o_Done_vs_model", int'(done), int'(m_done));
      if (sw !== prev_sw) tog_q.push_back(cyc);
      if (done === 1'b1) done_log.push_back(cyc);
      if (sw0 !== prev_sw0) tog0_q.push_back(cyc);
      if (done0 === 1'b1) done0_log.push_back(cyc);
      prev_sw = sw;
      prev_sw0 = sw0;
    end
  end

  // ---------------- directed sequence ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && done_log.size() == 0; i++) tick();
    chk(name, int'(done_log.size() > 0), 1);
  endtask

  // Hand-derived from seed ACE1: widths 2,1,1,5,7,8 give these offsets.
  int exp_off[7] = '{0, 2, 3, 4, 9, 16, 24};

  task automatic run_rise(input string tag);
    int t0;
    tog_q.delete(); done_log.delete();
    start = 1'b1; level = 1'b1; t0 = cyc + 1;
    tick();
    start = 1'b0;
    wait_done({tag, "_done_seen"}, 200);
    chk({tag, "_toggles"}, tog_q.size(), 7);
    for (int i = 0; i < 7 && i < tog_q.size(); i++)
      chk({tag, "_toggle_offset"}, tog_q[i] - t0, exp_off[i]);
    if (done_log.size() > 0) chk({tag, "_done_offset"}, done_log[0] - t0, 44);
    repeat (3) tick();
    chk({tag, "_final_level"}, int'(sw), 1);
    chk({tag, "_single_done"}, done_log.size(), 1);
  endtask

  initial begin
    int t0;
    rst = 1'b1; start = 1'b0; level = 1'b0; start0 = 1'b0; level0 = 1'b0;
    // 1. reset and idle
    repeat (3) tick();
    chk("rst_switch", int'(sw), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    repeat (6) tick();
    chk("idle_no_toggle", tog_q.size(), 0);
    chk("idle_busy", int'(busy), 0);

    // 2. rising command with bounce
    run_rise("rise1");

    // 3. same-level command
    tog_q.delete(); done_log.delete();
    start = 1'b1; level = 1'b1; t0 = cyc + 1;
    tick();
    start = 1'b0;
    chk("same_done_next", int'(done), 1);
    chk("same_busy", int'(busy), 0);
    repeat (4) tick();
    chk("same_no_toggle", tog_q.size(), 0);
    chk("same_single_done", done_log.size(), 1);
    if (done_log.size() > 0) chk("same_done_offset", done_log[0] - t0, 0);

    // 4. falling command with ignored starts in BOUNCE and SETTLE
    tog_q.delete(); done_log.delete();
    start = 1'b1; level = 1'b0;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; level = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200 && tog_q.size() < 7; i++) tick();
    chk("ign_reached_settle", int'(tog_q.size() >= 7), 1);
    repeat (3) tick();
    start = 1'b1; level = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ign_done_seen", 200);
    repeat (25) tick();
    chk("ign_single_done", done_log.size(), 1);
    chk("ign_toggles", tog_q.size(), 7);
    chk("ign_final_level", int'(sw), 0);

    // 5. reset mid-bounce, then identical rerun
    done_log.delete();
    start = 1'b1; level = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_switch", int'(sw), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    repeat (30) tick();
    chk("midrst_no_done", done_log.size(), 0);
    run_rise("rise2");

    // 6. zero bounce pairs
    tog0_q.delete(); done0_log.delete();
    start0 = 1'b1; level0 = 1'b1; t0 = cyc + 1;
    tick();
    start0 = 1'b0;
    chk("nb0_busy", int'(busy0), 1);
    for (int i = 0; i < 60 && done0_log.size() == 0; i++) tick();
    chk("nb0_done_seen", int'(done0_log.size() > 0), 1);
    chk("nb0_toggles", tog0_q.size(), 1);
    if (tog0_q.size() > 0) chk("nb0_edge_offset", tog0_q[0] - t0, 0);
    if (done0_log.size() > 0) chk("nb0_done_offset", done0_log[0] - t0, 20);
    chk("nb0_final_level", int'(sw0), 1);
    tick();
    chk("nb0_busy_after", int'(busy0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
